execute_unit_mc: RTL and testbench

//  Parametrised multi-cycle execute stage: ALU (add/sub/and/xor/or/shifts/iterative multiply),

---
 rtl/execute_unit_mc.sv | 175 +++++++++++++++++
 tb/tb_execute_unit_mc.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_unit_mc.sv
// execute_unit_mc
//   Multi-cycle execute stage. It holds one operation at a time. Single-cycle ALU
//   operations finish on the edge that accepts them. Multiply runs WIDTH shift-add
//   iterations and then finishes. The stage also holds the condition-code register
//   and computes the branch/cmov condition against the flags committed before the
//   operation was accepted.
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    upstream handshake (in_ready high only in IDLE)
//   in_alufun            0 ADD,1 SUB,2 AND,3 XOR,4 OR,5 SHL,6 SAR,7 MUL, 8-15 act as ADD
//   in_aluA/in_aluB      operands
//   in_set_cc            commit this operation's flags into cc
//   in_ifun              condition selector for out_cnd
//   out_valid/out_ready  downstream handshake
//   out_valE, out_cnd    result and condition outcome, held until consumed
//   cc                   committed {ZF,SF,OF}
//   busy                 high while the multiply iterates
module execute_unit_mc #(
  parameter int         WIDTH    = 64,
  parameter bit         MUL_EN   = 1'b1,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_alufun,
  input  logic [WIDTH-1:0] in_aluA,
  input  logic [WIDTH-1:0] in_aluB,
  input  logic             in_set_cc,
  input  logic [3:0]       in_ifun,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_valE,
  output logic             out_cnd,
  output logic [2:0]       cc,
  output logic             busy
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SUB = 4'd1;
  localparam logic [3:0] F_AND = 4'd2;
  localparam logic [3:0] F_XOR = 4'd3;
  localparam logic [3:0] F_OR  = 4'd4;
  localparam logic [3:0] F_SHL = 4'd5;
  localparam logic [3:0] F_SAR = 4'd6;
  localparam logic [3:0] F_MUL = 4'd7;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  // Map the unused codes onto ADD. When the multiplier is not built, MUL also maps
  // onto ADD, so the flag logic treats that case as ADD as well.
  function automatic logic [3:0] eff_fun(input logic [3:0] f);
    if (f > F_MUL) return F_ADD;
    if ((f == F_MUL) && !MUL_EN) return F_ADD;
    return f;
  endfunction

  function automatic logic [WIDTH-1:0] alu_op(input logic [3:0] f,
                                              input logic signed [WIDTH-1:0] a,
                                              input logic signed [WIDTH-1:0] b);
    logic [SH_W-1:0] sh;
    sh = a[SH_W-1:0];
    case (f)
      F_SUB:   return b - a;
      F_AND:   return b & a;
      F_XOR:   return b ^ a;
      F_OR:    return b | a;
      F_SHL:   return b << sh;
      F_SAR:   return b >>> sh;
      default: return b + a;
    endcase
  endfunction

  function automatic logic [2:0] flags(input logic [3:0] f,
                                       input logic signed [WIDTH-1:0] a,
                                       input logic signed [WIDTH-1:0] b,
                                       input logic signed [WIDTH-1:0] v);
    logic of;
    of = 1'b0;
    if (f == F_ADD)
      of = (a[WIDTH-1] == b[WIDTH-1]) && (v[WIDTH-1] != a[WIDTH-1]);
    else if (f == F_SUB)
      of = (a[WIDTH-1] != b[WIDTH-1]) && (v[WIDTH-1] != b[WIDTH-1]);
    return {(v == '0), v[WIDTH-1], of};
  endfunction

  function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] c);
    logic zf, sf, of;
    {zf, sf, of} = c;
    case (ifun)
      4'd0:    return 1'b1;
      4'd1:    return (sf ^ of) | zf;
      4'd2:    return sf ^ of;
      4'd3:    return zf;
      4'd4:    return ~zf;
      4'd5:    return ~(sf ^ of);
      4'd6:    return ~(sf ^ of) & ~zf;
      default: return 1'b0;
    endcase
  endfunction

  state_t                    state;
  logic                      set_cc_p0;
  logic signed [WIDTH-1:0]   mcand_p0;
  logic        [WIDTH-1:0]   mplier_p0;
  logic signed [WIDTH-1:0]   acc_p0;
  logic        [SH_W-1:0]    cnt_p0;

  logic        [3:0]         fun_in;
  logic        [WIDTH-1:0]   res_in;
  logic signed [WIDTH-1:0]   acc_next;

  always_comb begin
    fun_in   = eff_fun(in_alufun);
    res_in   = alu_op(fun_in, in_aluA, in_aluB);
    acc_next = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_MUL);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      out_valE  <= '0;
      out_cnd   <= 1'b0;
      cc        <= CC_RESET;
      set_cc_p0 <= 1'b0;
      cnt_p0    <= '0;
    end else begin
      case (state)
        // Accept: capture everything now so later input changes have no effect
        S_IDLE: begin
          if (in_valid) begin
            out_cnd   <= cond_eval(in_ifun, cc);
            set_cc_p0 <= in_set_cc;
            if (fun_in == F_MUL) begin
              mcand_p0  <= in_aluB;
              mplier_p0 <= in_aluA;
              acc_p0    <= '0;
              cnt_p0    <= '0;
              state     <= S_MUL;
            end else begin
              out_valE <= res_in;
              if (in_set_cc) cc <= flags(fun_in, in_aluA, in_aluB, res_in);
              state    <= S_DONE;
            end
          end
        end
        // One shift-add step per cycle; the last step goes straight to the result register
        S_MUL: begin
          acc_p0    <= acc_next;
          mcand_p0  <= mcand_p0 <<< 1;
          mplier_p0 <= mplier_p0 >> 1;
          cnt_p0    <= cnt_p0 + 1'b1;
          if (cnt_p0 == SH_W'(WIDTH - 1)) begin
            out_valE <= acc_next;
            if (set_cc_p0) cc <= flags(F_MUL, '0, '0, acc_next);
            state    <= S_DONE;
          end
        end
        // Result is held here until downstream takes it
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_unit_mc.sv
module tb_execute_unit_mc;
  localparam int W  = 64;
  localparam int SH = $clog2(W);

  logic         clock = 1'b0;
  logic         reset, in_valid, in_ready, in_set_cc, out_valid, out_ready, out_cnd, busy;
  logic [3:0]   in_alufun, in_ifun;
  logic [W-1:0] in_aluA, in_aluB, out_valE;
  logic [2:0]   cc;

  always #5 clock = ~clock;

  execute_unit_mc #(.WIDTH(W), .MUL_EN(1'b1), .CC_RESET(3'b100)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_alufun(in_alufun), .in_aluA(in_aluA), .in_aluB(in_aluB), .in_set_cc(in_set_cc),
    .in_ifun(in_ifun), .out_valid(out_valid), .out_ready(out_ready), .out_valE(out_valE),
    .out_cnd(out_cnd), .cc(cc), .busy(busy)
  );

  typedef struct { logic [W-1:0] v; logic c; } exp_t;
  exp_t       q[$];
  logic [2:0] m_cc;
  int         tests = 0;
  int         failed = 0;

  // Reference model
  function automatic logic [3:0] m_eff(input logic [3:0] f);
    if (f == 4'd7) return 4'd7;
    if (f > 4'd7)  return 4'd0;
    return f;
  endfunction

  function automatic logic [W-1:0] m_alu(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [SH-1:0] s;
    s = a[SH-1:0];
    case (m_eff(f))
      4'd0: return a + b;
      4'd1: return b - a;
      4'd2: return a & b;
      4'd3: return a ^ b;
      4'd4: return a | b;
      4'd5: return b << s;
      4'd6: return $signed(b) >>> s;
      4'd7: return a * b;
      default: return '0;
    endcase
  endfunction

  function automatic logic [2:0] m_flags(input logic [3:0] f, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [W-1:0] v);
    logic [W:0] wide;
    logic       o;
    o = 1'b0;
    if (m_eff(f) == 4'd0) begin
      wide = {a[W-1], a} + {b[W-1], b};
      o = wide[W] != wide[W-1];
    end else if (m_eff(f) == 4'd1) begin
      wide = {b[W-1], b} - {a[W-1], a};
      o = wide[W] != wide[W-1];
    end
    return {v == '0, v[W-1], o};
  endfunction

  function automatic logic m_cond(input logic [3:0] ifn, input logic [2:0] c);
    logic z, s, o;
    z = c[2]; s = c[1]; o = c[0];
    case (ifn)
      4'd0: return 1'b1;
      4'd1: return (s ^ o) | z;
      4'd2: return s ^ o;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return !(s ^ o);
      4'd6: return !(s ^ o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one operation, push its expected result, return after the accepting edge (+1)
  task automatic send(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sc, input logic [3:0] ifn);
    exp_t e;
    int   n;
    e.v = m_alu(f, a, b);
    e.c = m_cond(ifn, m_cc);
    if (sc) m_cc = m_flags(f, a, b, e.v);
    q.push_back(e);
    in_valid = 1'b1; in_alufun = f; in_aluA = a; in_aluB = b; in_set_cc = sc; in_ifun = ifn;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clock); #1; n++;
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_alufun = 4'hF; in_aluA = '1; in_aluB = '1; in_set_cc = 1'b1; in_ifun = 4'd0;
  endtask

  task automatic wait_out(input int budget, output int cycles);
    cycles = 0;
    while (!out_valid && cycles < budget) begin
      @(posedge clock); #1; cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_alufun = '0; in_aluA = '0; in_aluB = '0; in_set_cc = 1'b0; in_ifun = '0;
    repeat (3) @(posedge clock);
    #1;
    tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (out_valE !== '0) begin failed++; $display("FAIL reset_valE: got %h want 0", out_valE); end
    tests++; if (out_cnd !== 1'b0) begin failed++; $display("FAIL reset_cnd: got %b want 0", out_cnd); end
    tests++; if (cc !== 3'b100) begin failed++; $display("FAIL reset_cc: got %b want 100", cc); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    m_cc = 3'b100;
    q.delete();
  endtask

  task automatic test_add_overflow;
    exp_t e; int cyc;
    send(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'd0);
    wait_out(200, cyc);
    tests++; if (out_valid !== 1'b1 || cyc != 0) begin failed++; $display("FAIL add_latency: valid=%b cycles=%0d want 1/0", out_valid, cyc); end
    e = q.pop_front();
    tests++; if (out_valE !== e.v) begin failed++; $display("FAIL add_valE: got %h want %h", out_valE, e.v); end
    tests++; if (cc !== m_cc) begin failed++; $display("FAIL add_cc: got %b want %b", cc, m_cc); end
    @(posedge clock); #1;
  endtask

  task automatic test_sub_cond;
    exp_t e; int cyc;
    send(4'd1, 64'd5, 64'd5, 1'b1, 4'd0);
    wait_out(200, cyc);
    e = q.pop_front();
    tests++; if (out_valid !== 1'b1 || out_valE !== e.v) begin failed++; $display("FAIL sub_valE: valid=%b got %h want %h", out_valid, out_valE, e.v); end
    tests++; if (cc !== m_cc) begin failed++; $display("FAIL sub_cc: got %b want %b", cc, m_cc); end
    @(posedge clock); #1;
    send(4'd0, 64'd1, 64'd2, 1'b0, 4'd3);
    wait_out(200, cyc);
    e = q.pop_front();
    tests++; if (out_valid !== 1'b1 || out_cnd !== e.c) begin failed++; $display("FAIL cond_E: valid=%b got %b want %b", out_valid, out_cnd, e.c); end
    tests++; if (out_valE !== e.v) begin failed++; $display("FAIL cond_E_valE: got %h want %h", out_valE, e.v); end
    @(posedge clock); #1;
  endtask

  task automatic test_shifts;
    exp_t e; int cyc;
    send(4'd6, 64'd4, 64'hF000_0000_0000_0000, 1'b0, 4'd0);
    wait_out(200, cyc);
    e = q.pop_front();
    tests++; if (out_valid !== 1'b1 || out_valE !== e.v) begin failed++; $display("FAIL sar: valid=%b got %h want %h", out_valid, out_valE, e.v); end
    @(posedge clock); #1;
    send(4'd5, 64'd68, 64'd1, 1'b0, 4'd0);
    wait_out(200, cyc);
    e = q.pop_front();
    tests++; if (out_valid !== 1'b1 || out_valE !== e.v) begin failed++; $display("FAIL shl: valid=%b got %h want %h", out_valid, out_valE, e.v); end
    @(posedge clock); #1;
  endtask

  task automatic test_mul;
    exp_t e; int cyc, bz;
    send(4'd7, 64'd12345, 64'd678, 1'b1, 4'd0);
    cyc = 0; bz = 0;
    while (!out_valid && cyc < 200) begin
      if (busy) bz++;
      @(posedge clock); #1; cyc++;
    end
    tests++; if (cyc != W) begin failed++; $display("FAIL mul_latency: got %0d edges want %0d", cyc, W); end
    tests++; if (bz != W) begin failed++; $display("FAIL mul_busy: got %0d cycles want %0d", bz, W); end
    e = q.pop_front();
    tests++; if (out_valE !== e.v) begin failed++; $display("FAIL mul_valE: got %h want %h", out_valE, e.v); end
    tests++; if (cc !== m_cc) begin failed++; $display("FAIL mul_cc: got %b want %b", cc, m_cc); end
    @(posedge clock); #1;
  endtask

  task automatic test_backpressure;
    exp_t e; int cyc;
    out_ready = 1'b0;
    send(4'd3, 64'h00FF_00FF_1234_5678, 64'h0F0F_0F0F_0000_FFFF, 1'b0, 4'd4);
    wait_out(200, cyc);
    e = q.pop_front();
    in_valid = 1'b1; in_alufun = 4'd1; in_aluA = 64'd1; in_aluB = 64'd1; in_set_cc = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tests++; if (out_valid !== 1'b1 || out_valE !== e.v || out_cnd !== e.c)
        begin failed++; $display("FAIL stall_hold%0d: valid=%b valE=%h cnd=%b want 1 %h %b", k, out_valid, out_valE, out_cnd, e.v, e.c); end
      tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL stall_in_ready%0d: got %b want 0", k, in_ready); end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failed++; $display("FAIL stall_release: valid=%b ready=%b want 0 1", out_valid, in_ready); end
    tests++; if (cc !== m_cc) begin failed++; $display("FAIL stall_cc: got %b want %b", cc, m_cc); end
  endtask

  task automatic test_reset_mid_mul;
    send(4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b1, 4'd0);
    repeat (10) @(posedge clock);
    #1;
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL midmul_busy: got %b want 1", busy); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      begin failed++; $display("FAIL midmul_abort: valid=%b ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy); end
    tests++; if (cc !== 3'b100) begin failed++; $display("FAIL midmul_cc: got %b want 100", cc); end
    m_cc = 3'b100;
    q.delete();
  endtask

  task automatic test_back_to_back;
    exp_t e; int cyc;
    logic [3:0] f, ifn; logic [W-1:0] a, b; logic sc;
    for (int i = 0; i < 40; i++) begin
      f = 4'($urandom_range(0, 15));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 7 == 0) a = b;
      if (i % 9 == 0) b = 64'h7FFF_FFFF_FFFF_FFF0;
      sc = 1'($urandom_range(0, 1));
      ifn = 4'($urandom_range(0, 15));
      send(f, a, b, sc, ifn);
      tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL b2b_ready%0d: got %b want 0", i, in_ready); end
      wait_out(200, cyc);
      tests++; if (out_valid !== 1'b1 || cyc != ((m_eff(f) == 4'd7) ? W : 0))
        begin failed++; $display("FAIL b2b_latency%0d: valid=%b cycles=%0d fun=%0d", i, out_valid, cyc, f); end
      e = q.pop_front();
      tests++; if (out_valE !== e.v || out_cnd !== e.c)
        begin failed++; $display("FAIL b2b_result%0d: fun=%0d valE=%h cnd=%b want %h %b", i, f, out_valE, out_cnd, e.v, e.c); end
      tests++; if (cc !== m_cc) begin failed++; $display("FAIL b2b_cc%0d: got %b want %b", i, cc, m_cc); end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_add_overflow;
    test_sub_cond;
    test_shifts;
    test_mul;
    test_backpressure;
    test_reset_mid_mul;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
